// File: rtl/mem_scan_pkg.sv
// Shared types for the multi-bank scan reader: FSM state encoding and skid-FIFO sizing.
package mem_scan_pkg;

    typedef enum logic [1:0] {
        SCAN_IDLE,
        SCAN_READ,
        SCAN_DRAIN
    } scan_state_e;

    // Two extra entries cover the word being popped and the one being pushed in the same cycle.
    function automatic int unsigned fifo_depth(input int unsigned output_delay);
        return output_delay + 2;
    endfunction

endpackage

// File: rtl/scan_skid_fifo.sv
// Synchronous FIFO with occupancy count and flush; a push is accepted when full if a pop
// happens in the same cycle.
module scan_skid_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 3,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop, full;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full    = (count_q == CntW'(Depth));
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && (!full || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (do_pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/mem_multi_bank_scan_reader.sv
// Walks every bank/address of a multi-bank memory and streams the words out with tags.
// Optional MEM_SCAN_READER_CHECKSUM_EN adds an XOR checksum of all streamed words.
module mem_multi_bank_scan_reader
    import mem_scan_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned NUM_BANKS    = 2,
    parameter int unsigned OUTPUT_DELAY = 1,
    parameter int unsigned BANK_WIDTH   = $clog2(NUM_BANKS),
    parameter int unsigned ADDR_WIDTH   = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  reb,
    output logic [BANK_WIDTH-1:0] bankb,
    output logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] dob,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [BANK_WIDTH-1:0] m_bank,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic                  m_last,
    output logic                  busy,
`ifdef MEM_SCAN_READER_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] checksum,
`endif
    output logic                  done_pulse
);

    typedef struct packed {
        logic                  last;
        logic [BANK_WIDTH-1:0] bank;
        logic [ADDR_WIDTH-1:0] addr;
    } tag_t;

    localparam int unsigned FifoDepth = fifo_depth(OUTPUT_DELAY);
    localparam int unsigned TagW      = $bits(tag_t);
    localparam int unsigned EntryW    = DATA_WIDTH + TagW;
    localparam int unsigned CntW      = $clog2(FifoDepth + 1);

    scan_state_e           state_q;
    logic [BANK_WIDTH-1:0] bank_q, bankb_q;
    logic [ADDR_WIDTH-1:0] addr_q, addrb_q;
    logic                  done_q;

    logic                  abort_act, start_act, last_issue, credit_ok, reb_int, hs;
    logic [CntW-1:0]       fifo_count, in_flight;
    logic [CntW:0]         outstanding;
    logic                  push, fifo_empty;
    tag_t                  issue_tag, push_tag, head_tag;
    logic [EntryW-1:0]     fifo_wdata, fifo_rdata;

    assign abort_act  = abort && (state_q != SCAN_IDLE);
    assign start_act  = start && !abort && (state_q == SCAN_IDLE);
    assign last_issue = (bank_q == BANK_WIDTH'(NUM_BANKS - 1)) &&
                        (addr_q == ADDR_WIDTH'(DEPTH - 1));

    // Every read issued must already own a FIFO slot so backpressure never drops a word.
    assign outstanding = {1'b0, in_flight} + {1'b0, fifo_count};
    assign credit_ok   = outstanding < (CntW + 1)'(FifoDepth);
    assign reb_int     = (state_q == SCAN_READ) && !abort && credit_ok;

    assign issue_tag = '{last: last_issue, bank: bank_q, addr: addr_q};

    generate
        if (OUTPUT_DELAY == 0) begin : g_no_pipe
            assign push      = reb_int;
            assign push_tag  = issue_tag;
            assign in_flight = '0;
        end else begin : g_pipe
            logic [OUTPUT_DELAY-1:0] vld_q;
            tag_t                    tag_q [OUTPUT_DELAY];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    vld_q <= '0;
                    for (int i = 0; i < int'(OUTPUT_DELAY); i++) begin
                        tag_q[i] <= '0;
                    end
                end else begin
                    vld_q[0] <= reb_int;
                    tag_q[0] <= issue_tag;
                    for (int i = 1; i < int'(OUTPUT_DELAY); i++) begin
                        vld_q[i] <= vld_q[i-1] && !abort_act;
                        tag_q[i] <= tag_q[i-1];
                    end
                end
            end

            assign push      = vld_q[OUTPUT_DELAY-1];
            assign push_tag  = tag_q[OUTPUT_DELAY-1];
            assign in_flight = CntW'($countones(vld_q));
        end
    endgenerate

    assign fifo_wdata = {dob, push_tag};

    scan_skid_fifo #(
        .Width (EntryW),
        .Depth (FifoDepth),
        .CntW  (CntW)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush_i (abort_act),
        .push_i  (push),
        .wdata_i (fifo_wdata),
        .pop_i   (hs),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head_tag = tag_t'(fifo_rdata[TagW-1:0]);
    assign m_valid  = !fifo_empty;
    assign m_data   = fifo_rdata[EntryW-1:TagW];
    assign m_bank   = head_tag.bank;
    assign m_addr   = head_tag.addr;
    assign m_last   = m_valid && head_tag.last;
    assign hs       = m_valid && m_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SCAN_IDLE;
            bank_q  <= '0;
            addr_q  <= '0;
            bankb_q <= '0;
            addrb_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (reb_int) begin
                bankb_q <= bank_q;
                addrb_q <= addr_q;
                if (addr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    addr_q <= '0;
                    bank_q <= bank_q + 1'b1;
                end else begin
                    addr_q <= addr_q + 1'b1;
                end
            end
            unique case (state_q)
                SCAN_IDLE: begin
                    if (start_act) begin
                        state_q <= SCAN_READ;
                        bank_q  <= '0;
                        addr_q  <= '0;
                    end
                end
                SCAN_READ: begin
                    if (abort) begin
                        state_q <= SCAN_IDLE;
                    end else if (reb_int && last_issue) begin
                        state_q <= SCAN_DRAIN;
                    end
                end
                SCAN_DRAIN: begin
                    if (abort) begin
                        state_q <= SCAN_IDLE;
                    end else if (hs && m_last) begin
                        state_q <= SCAN_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= SCAN_IDLE;
            endcase
        end
    end

    // The read port keeps showing the last issued location while idle.
    assign reb        = reb_int;
    assign bankb      = reb_int ? bank_q : bankb_q;
    assign addrb      = reb_int ? addr_q : addrb_q;
    assign busy       = (state_q != SCAN_IDLE);
    assign done_pulse = done_q;

`ifdef MEM_SCAN_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            checksum_q <= '0;
        end else if (start_act) begin
            checksum_q <= '0;
        end else if (hs) begin
            checksum_q <= checksum_q ^ m_data;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_mem_multi_bank_scan_reader.sv
// Bench for the scan reader: three instances with read latency 0, 1 and 2 share one memory image.
`timescale 1ns/1ps
module tb_mem_multi_bank_scan_reader;

    localparam int NI = 3;
    localparam int NB = 2;
    localparam int DP = 4;
    localparam int NW = NB * DP;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic       start      [NI];
    logic       abort      [NI];
    logic       reb        [NI];
    logic [0:0] bankb      [NI];
    logic [1:0] addrb      [NI];
    logic [7:0] dob        [NI];
    logic       m_valid    [NI];
    logic       m_ready    [NI];
    logic [7:0] m_data     [NI];
    logic [0:0] m_bank     [NI];
    logic [1:0] m_addr     [NI];
    logic       m_last     [NI];
    logic       busy       [NI];
    logic       done_pulse [NI];
`ifdef MEM_SCAN_READER_CHECKSUM_EN
    logic [7:0] checksum   [NI];
`endif

    logic [7:0] mem [NB][DP];
    int errs = 0;
    int checks = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_multi_bank_scan_reader #(
            .DATA_WIDTH   (8),
            .DEPTH        (DP),
            .NUM_BANKS    (NB),
            .OUTPUT_DELAY (g)
        ) u_dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .start      (start[g]),
            .abort      (abort[g]),
            .reb        (reb[g]),
            .bankb      (bankb[g]),
            .addrb      (addrb[g]),
            .dob        (dob[g]),
            .m_valid    (m_valid[g]),
            .m_ready    (m_ready[g]),
            .m_data     (m_data[g]),
            .m_bank     (m_bank[g]),
            .m_addr     (m_addr[g]),
            .m_last     (m_last[g]),
            .busy       (busy[g]),
`ifdef MEM_SCAN_READER_CHECKSUM_EN
            .checksum   (checksum[g]),
`endif
            .done_pulse (done_pulse[g])
        );
        if (g == 0) begin : g_async
            assign dob[g] = mem[bankb[g]][addrb[g]];
        end else begin : g_sync
            logic [7:0] p [g];
            always @(posedge clk) begin
                p[0] <= reb[g] ? mem[bankb[g]][addrb[g]] : 8'hxx;
                for (int i = 1; i < g; i++) p[i] <= p[i-1];
            end
            assign dob[g] = p[g-1];
        end
    end

    function automatic logic [11:0] exp_word(input int i);
        return {mem[i / DP][i % DP], 1'(i / DP), 2'(i % DP), 1'(i == NW - 1)};
    endfunction

    task automatic fill_pattern();
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < DP; a++) mem[b][a] = 8'(b * 16 + a);
    endtask

    task automatic fill_random();
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < DP; a++) mem[b][a] = 8'($urandom);
    endtask

    task automatic fill_zero();
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < DP; a++) mem[b][a] = 8'h00;
    endtask

    // One full scan on instance k with m_ready high pct% of cycles, checked against the model.
    task automatic do_scan(input int k, input int pct, input string nm);
        int idx, issued, cyc, last_hs;
        logic stalled;
        logic [11:0] held, w, ew;
        idx = 0; issued = 0; cyc = 0; last_hs = -1; stalled = 1'b0; held = '0;
        @(negedge clk); start[k] = 1'b1; m_ready[k] = 1'b0;
        @(negedge clk); start[k] = 1'b0;
        while (idx < NW && cyc < 300) begin
            m_ready[k] = ($urandom_range(99) < pct);
            #1;
            if (reb[k]) begin
                checks++;
                if (issued >= NW || issued - idx >= k + 2 || bankb[k] !== 1'(issued / DP) ||
                    addrb[k] !== 2'(issued % DP)) begin
                    errs++;
                    $display("FAIL %s_issue k=%0d: reb with outstanding=%0d bank=%0d addr=%0d, required outstanding<%0d bank=%0d addr=%0d (read #%0d of %0d)",
                             nm, k, issued - idx, bankb[k], addrb[k], k + 2, issued / DP,
                             issued % DP, issued, NW);
                end
                issued++;
            end
            w = {m_data[k], m_bank[k], m_addr[k], m_last[k]};
            if (stalled) begin
                checks++;
                if (m_valid[k] !== 1'b1 || w !== held) begin
                    errs++;
                    $display("FAIL %s_stable k=%0d: valid=%b word=%h, required valid=1 word=%h",
                             nm, k, m_valid[k], w, held);
                end
            end
            stalled = 1'b0;
            if (m_valid[k] === 1'b1) begin
                ew = exp_word(idx);
                checks++;
                if (w !== ew) begin
                    errs++;
                    $display("FAIL %s_word k=%0d idx=%0d: {data,bank,addr,last}=%h, required %h",
                             nm, k, idx, w, ew);
                end
                if (m_ready[k]) begin
                    if (pct == 100 && idx > 0) begin
                        checks++;
                        if (cyc != last_hs + 1) begin
                            errs++;
                            $display("FAIL %s_gap k=%0d idx=%0d: word gap=%0d cycles, required 1",
                                     nm, k, idx, cyc - last_hs);
                        end
                    end
                    last_hs = cyc;
                    idx++;
                end else begin
                    stalled = 1'b1;
                    held = w;
                end
            end
            @(negedge clk);
            cyc++;
        end
        m_ready[k] = 1'b0;
        checks++;
        if (idx != NW) begin
            errs++;
            $display("FAIL %s_timeout k=%0d: words=%0d, required %0d", nm, k, idx, NW);
        end
        #1;
        checks++;
        if ({done_pulse[k], busy[k]} !== 2'b10) begin
            errs++;
            $display("FAIL %s_done k=%0d: done_pulse=%b busy=%b, required 1 0",
                     nm, k, done_pulse[k], busy[k]);
        end
        @(negedge clk); #1;
        checks++;
        if (done_pulse[k] !== 1'b0) begin
            errs++;
            $display("FAIL %s_done_width k=%0d: done_pulse=%b, required 0", nm, k, done_pulse[k]);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < NI; k++) begin
            checks++;
            if ({reb[k], bankb[k], addrb[k], m_valid[k], m_data[k], m_bank[k], m_addr[k],
                 m_last[k], busy[k], done_pulse[k]} !== 19'h0) begin
                errs++;
                $display("FAIL reset k=%0d: reb=%b bankb=%h addrb=%h valid=%b data=%h bank=%h addr=%h last=%b busy=%b done=%b, required all 0",
                         k, reb[k], bankb[k], addrb[k], m_valid[k], m_data[k], m_bank[k],
                         m_addr[k], m_last[k], busy[k], done_pulse[k]);
            end
        end
    endtask

    task automatic test_stream_delay1();
        fill_pattern();
        do_scan(1, 100, "stream_d1");
    endtask

    task automatic test_backpressure_delay2();
        fill_pattern();
        do_scan(2, 50, "bp_d2");
    endtask

    task automatic test_stall_async();
        int rebs, idx, cyc;
        logic [11:0] w, ew;
        fill_pattern();
        rebs = 0;
        @(negedge clk); start[0] = 1'b1; m_ready[0] = 1'b0;
        @(negedge clk); start[0] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (reb[0]) rebs++;
            if (m_valid[0] === 1'b1) begin
                checks++;
                if ({m_data[0], m_bank[0], m_addr[0]} !== 11'h0) begin
                    errs++;
                    $display("FAIL stall_hold c=%0d: data=%h bank=%h addr=%h, required 00 0 0",
                             c, m_data[0], m_bank[0], m_addr[0]);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (rebs != 2 || m_valid[0] !== 1'b1) begin
            errs++;
            $display("FAIL stall_credit: reads=%0d valid=%b, required 2 1", rebs, m_valid[0]);
        end
        idx = 0; cyc = 0;
        m_ready[0] = 1'b1;
        while (idx < NW && cyc < 50) begin
            #1;
            if (m_valid[0] === 1'b1) begin
                w = {m_data[0], m_bank[0], m_addr[0], m_last[0]};
                ew = exp_word(idx);
                checks++;
                if (w !== ew) begin
                    errs++;
                    $display("FAIL stall_release idx=%0d: word=%h, required %h", idx, w, ew);
                end
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        m_ready[0] = 1'b0;
        #1;
        checks++;
        if (idx != NW || done_pulse[0] !== 1'b1) begin
            errs++;
            $display("FAIL stall_done: words=%0d done=%b, required %0d 1", idx, done_pulse[0], NW);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int hs, cyc;
        fill_pattern();
        hs = 0; cyc = 0;
        @(negedge clk); start[1] = 1'b1; m_ready[1] = 1'b1;
        @(negedge clk); start[1] = 1'b0;
        while (hs < 3 && cyc < 50) begin
            #1;
            if (m_valid[1] && m_ready[1]) hs++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (hs != 3) begin
            errs++;
            $display("FAIL abort_setup: handshakes=%0d, required 3", hs);
        end
        abort[1] = 1'b1; m_ready[1] = 1'b0;
        #1;
        checks++;
        if (reb[1] !== 1'b0) begin
            errs++;
            $display("FAIL abort_reb: reb=%b, required 0", reb[1]);
        end
        @(negedge clk); abort[1] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if ({m_valid[1], busy[1], done_pulse[1], reb[1]} !== 4'b0) begin
                errs++;
                $display("FAIL abort_idle c=%0d: valid=%b busy=%b done=%b reb=%b, required 0 0 0 0",
                         c, m_valid[1], busy[1], done_pulse[1], reb[1]);
            end
            @(negedge clk);
        end
        do_scan(1, 100, "abort_restart");
    endtask

    task automatic test_reset_mid_drain();
        int cyc;
        logic seen;
        fill_pattern();
        cyc = 0; seen = 1'b0;
        @(negedge clk); start[2] = 1'b1; m_ready[2] = 1'b1;
        @(negedge clk); start[2] = 1'b0;
        while (!seen && cyc < 50) begin
            #1;
            if (reb[2] && bankb[2] == 1'b1 && addrb[2] == 2'd3) seen = 1'b1;
            @(negedge clk);
            cyc++;
        end
        m_ready[2] = 1'b0;
        start[2] = 1'b1;
        #1;
        checks++;
        if (!seen || busy[2] !== 1'b1 || reb[2] !== 1'b0) begin
            errs++;
            $display("FAIL drain_entry: last_read_seen=%b busy=%b reb=%b, required 1 1 0",
                     seen, busy[2], reb[2]);
        end
        @(negedge clk); start[2] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (reb[2] !== 1'b0 || busy[2] !== 1'b1 || m_valid[2] !== 1'b1) begin
                errs++;
                $display("FAIL start_in_drain c=%0d: reb=%b busy=%b valid=%b, required 0 1 1",
                         c, reb[2], busy[2], m_valid[2]);
            end
            @(negedge clk);
        end
        #2 reset_n = 1'b0;
        #1;
        test_reset();
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
    endtask

`ifdef MEM_SCAN_READER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] x;
        fill_zero();
        do_scan(1, 100, "csum_zero");
        checks++;
        if (checksum[1] !== 8'h00) begin
            errs++;
            $display("FAIL csum_zero: checksum=%h, required 00", checksum[1]);
        end
        fill_pattern();
        do_scan(1, 100, "csum_pattern");
        checks++;
        if (checksum[1] !== 8'h00) begin
            errs++;
            $display("FAIL csum_pattern: checksum=%h, required 00", checksum[1]);
        end
        fill_random();
        x = 8'h00;
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < DP; a++) x ^= mem[b][a];
        do_scan(1, 70, "csum_rand");
        repeat (2) @(negedge clk);
        checks++;
        if (checksum[1] !== x) begin
            errs++;
            $display("FAIL csum_rand: checksum=%h, required %h", checksum[1], x);
        end
    endtask
`endif

    initial begin
        for (int k = 0; k < NI; k++) begin
            start[k] = 1'b0;
            abort[k] = 1'b0;
            m_ready[k] = 1'b0;
        end
        fill_pattern();
        #1;
        test_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        test_stream_delay1();
        test_backpressure_delay2();
        test_stall_async();
        test_abort();
        test_reset_mid_drain();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < NI; k++) begin
                fill_random();
                do_scan(k, 60, "rand");
            end
        end
        fill_pattern();
        do_scan(2, 100, "back_to_back");
        do_scan(2, 100, "back_to_back");
`ifdef MEM_SCAN_READER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
